mem_port_arbiter: RTL and testbench

- Shares the single memory bus between the instruction-fetch requester and the data (load/store) requester of the pipeline.
- One transaction is outstanding at a time. Data has priority; a starvation counter guarantees fetch progress.
- Supports fetch cancellation: when the decode stage discards a taken-jump shadow, the in-flight fetch response is dropped.

---
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory bus between the instruction-fetch port (i_*) and the
// load/store port (d_*). Only one bus transaction is outstanding at a time.
// Data wins arbitration unless fetch has lost STARVE_LIMIT contended
// arbitrations in a row, in which case fetch wins the next one. A fetch may be
// cancelled while issued or in flight: the bus transaction still completes, but
// its response is not delivered to the fetch port.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_req/i_addr             fetch request (held until i_ready)
//   i_cancel                 drop the response of the current fetch
//   i_ready                  fetch request accepted by memory this cycle
//   i_rvalid/i_rdata         fetch read response
//   d_req/d_addr/d_write     data request (held until d_ready)
//   d_wdata/d_wstrb          store data and byte enables
//   d_ready                  data request accepted by memory this cycle
//   d_rvalid/d_rdata         load data or store acknowledge
//   m_req/m_addr/m_write     registered memory request
//   m_wdata/m_wstrb          registered store data and byte enables
//   m_ready                  memory accepts m_req this cycle
//   m_rvalid/m_rdata         memory response
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4  // 1..15
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_cancel,
  output logic        i_ready,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,

  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,

  output logic        m_req,
  output logic [31:0] m_addr,
  output logic        m_write,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic       {OWN_DATA, OWN_FETCH} owner_t;

  localparam logic [3:0] STARVE_MAX = 4'd15;
  localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

  state_t      state, state_nxt;
  owner_t      owner, owner_nxt;
  logic [3:0]  starve_cnt, starve_nxt;
  logic        drop, drop_nxt;
  logic        fetch_wins;

  logic        m_req_nxt;
  logic [31:0] m_addr_nxt;
  logic        m_write_nxt;
  logic [31:0] m_wdata_nxt;
  logic [3:0]  m_wstrb_nxt;

  // A cancel only matters while a fetch owns the bus.
  logic cancel_hit;
  assign cancel_hit = i_cancel && (owner == OWN_FETCH);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every control and bus register is cleared by the async reset, so an
  // abandoned transaction leaves no owner or pending drop behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_DATA;
      starve_cnt <= '0;
      drop       <= 1'b0;
      m_req      <= 1'b0;
      m_addr     <= '0;
      m_write    <= 1'b0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the
      // same pre-edge values, independent of statement order.
      state      <= state_nxt;
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
      drop       <= drop_nxt;
      m_req      <= m_req_nxt;
      m_addr     <= m_addr_nxt;
      m_write    <= m_write_nxt;
      m_wdata    <= m_wdata_nxt;
      m_wstrb    <= m_wstrb_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can infer a latch.
    state_nxt   = state;
    owner_nxt   = owner;
    starve_nxt  = starve_cnt;
    drop_nxt    = drop;
    m_req_nxt   = m_req;
    m_addr_nxt  = m_addr;
    m_write_nxt = m_write;
    m_wdata_nxt = m_wdata;
    m_wstrb_nxt = m_wstrb;
    fetch_wins  = i_req && (!d_req || (starve_cnt >= LIMIT));

    unique case (state)
      IDLE: begin
        m_req_nxt = 1'b0;
        if (d_req || i_req) begin
          m_req_nxt = 1'b1;
          state_nxt = ISSUE;
          if (fetch_wins) begin
            owner_nxt   = OWN_FETCH;
            m_addr_nxt  = i_addr;
            m_write_nxt = 1'b0;
            m_wdata_nxt = '0;
            m_wstrb_nxt = '0;
            starve_nxt  = '0;
          end else begin
            owner_nxt   = OWN_DATA;
            m_addr_nxt  = d_addr;
            m_write_nxt = d_write;
            m_wdata_nxt = d_wdata;
            m_wstrb_nxt = d_wstrb;
            // Only a contended loss counts towards fetch starvation.
            if (i_req && (starve_cnt != STARVE_MAX)) begin
              starve_nxt = starve_cnt + 4'd1;
            end
          end
        end
      end

      ISSUE: begin
        if (cancel_hit) drop_nxt = 1'b1;
        if (m_ready) begin
          m_req_nxt = 1'b0;
          state_nxt = WAIT;
        end
      end

      WAIT: begin
        if (m_rvalid) begin
          // The response is consumed (or swallowed) here, so drop is spent.
          drop_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (cancel_hit) begin
          drop_nxt = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Requester handshakes and response routing
  // ---------------------------------------------------------------------------
  assign i_ready  = (state == ISSUE) && m_ready && (owner == OWN_FETCH);
  assign d_ready  = (state == ISSUE) && m_ready && (owner == OWN_DATA);

  // A cancel arriving with the response suppresses it just like a stored drop.
  assign i_rvalid = (state == WAIT) && m_rvalid && (owner == OWN_FETCH)
                    && !drop && !i_cancel;
  assign d_rvalid = (state == WAIT) && m_rvalid && (owner == OWN_DATA);

  // Data buses are shared; the rvalid strobes qualify them.
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with STARVE_LIMIT = 4. Inputs change
// 2 time units after each rising edge and outputs are sampled 1 unit later,
// well away from the clock edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_cancel, i_ready, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_write, d_ready, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        m_req, m_write, m_ready, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_cancel (i_cancel),
    .i_ready  (i_ready),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_write  (d_write),
    .d_wdata  (d_wdata),
    .d_wstrb  (d_wstrb),
    .d_ready  (d_ready),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_req    (m_req),
    .m_addr   (m_addr),
    .m_write  (m_write),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_ready  (m_ready),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to the drive point of the next cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One complete transaction starting from an IDLE cycle. Memory accepts on
  // the first m_req and answers two cycles after the request is presented.
  task automatic run_txn(input string tag, input logic ireq, input logic dreq,
                         input logic exp_fetch, input logic [31:0] exp_addr,
                         input logic exp_write, input logic [31:0] exp_wdata,
                         input logic [3:0] exp_wstrb, input logic [31:0] rdata);
    i_req = ireq; d_req = dreq; m_ready = 1'b1;
    #1;
    check({tag, ".idle_m_req"}, m_req, 32'd0);
    tick(); #1;
    check({tag, ".m_req"},   m_req,   32'd1);
    check({tag, ".m_addr"},  m_addr,  exp_addr);
    check({tag, ".m_write"}, m_write, 32'(exp_write));
    check({tag, ".m_wdata"}, m_wdata, exp_wdata);
    check({tag, ".m_wstrb"}, m_wstrb, 32'(exp_wstrb));
    check({tag, ".i_ready"}, i_ready, 32'(exp_fetch));
    check({tag, ".d_ready"}, d_ready, 32'(!exp_fetch));
    tick();
    if (exp_fetch) i_req = 1'b0; else d_req = 1'b0;
    m_ready = 1'b0;
    #1;
    check({tag, ".wait_m_req"},   m_req,   32'd0);
    check({tag, ".wait_i_ready"}, i_ready, 32'd0);
    check({tag, ".wait_d_ready"}, d_ready, 32'd0);
    tick();
    m_rvalid = 1'b1; m_rdata = rdata;
    #1;
    check({tag, ".i_rvalid"}, i_rvalid, 32'(exp_fetch));
    check({tag, ".d_rvalid"}, d_rvalid, 32'(!exp_fetch));
    if (exp_fetch) check({tag, ".i_rdata"}, i_rdata, rdata);
    else           check({tag, ".d_rdata"}, d_rdata, rdata);
    tick();
    m_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    i_req = 1'b0; i_addr = '0; i_cancel = 1'b0;
    d_req = 1'b0; d_addr = '0; d_write = 1'b0; d_wdata = '0; d_wstrb = '0;
    m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF;

    // ---- Reset state (memory strobes high to show they are gated) ----
    #1 rst = 1'b1;
    #2;
    check("rst.m_req",    m_req,    32'd0);
    check("rst.m_addr",   m_addr,   32'd0);
    check("rst.m_write",  m_write,  32'd0);
    check("rst.m_wdata",  m_wdata,  32'd0);
    check("rst.m_wstrb",  m_wstrb,  32'd0);
    check("rst.i_ready",  i_ready,  32'd0);
    check("rst.d_ready",  d_ready,  32'd0);
    check("rst.i_rvalid", i_rvalid, 32'd0);
    check("rst.d_rvalid", d_rvalid, 32'd0);
    check("rst.starve",   dut.starve_cnt, 32'd0);
    tick();
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    tick();
    rst = 1'b0;
    tick();

    // ---- Single fetch ----
    i_addr = 32'h100;
    run_txn("fetch1", 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 4'h0,
            32'hDEAD_BEEF);

    // ---- Contention: store wins, fetch follows after one dead cycle ----
    i_addr = 32'h104;
    d_addr = 32'h200; d_write = 1'b1; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
    run_txn("cont.data", 1'b1, 1'b1, 1'b0, 32'h200, 1'b1, 32'h1234_5678, 4'hF,
            32'h0000_0001);
    run_txn("cont.fetch", 1'b1, 1'b0, 1'b1, 32'h104, 1'b0, 32'h0, 4'h0,
            32'h1111_0000);

    // ---- Starvation: four contended data wins, then fetch ----
    i_addr = 32'h700;
    d_write = 1'b0; d_wdata = 32'h5555_AAAA; d_wstrb = 4'h3;
    for (int k = 0; k < 5; k++) begin
      d_addr = 32'h800 + 32'(k * 4);
      if (k < 4)
        run_txn($sformatf("starve%0d", k), 1'b1, 1'b1, 1'b0, d_addr, 1'b0,
                32'h5555_AAAA, 4'h3, 32'h2000 + 32'(k));
      else
        run_txn("starve4", 1'b1, 1'b1, 1'b1, 32'h700, 1'b0, 32'h0, 4'h0,
                32'h3333_4444);
    end
    check("starve.cleared", dut.starve_cnt, 32'd0);

    // ---- Cancel in WAIT, queued load proceeds ----
    i_addr = 32'h300; i_req = 1'b1; d_req = 1'b0; m_ready = 1'b1;
    tick(); #1;
    check("cancel.m_addr",  m_addr,  32'h300);
    check("cancel.i_ready", i_ready, 32'd1);
    d_addr = 32'h400; d_write = 1'b0; d_wdata = 32'h0; d_wstrb = 4'h0;
    d_req = 1'b1;
    tick();
    i_req = 1'b0; m_ready = 1'b0; i_cancel = 1'b1;
    tick();
    i_cancel = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0BAD_0BAD;
    #1;
    check("cancel.i_rvalid", i_rvalid, 32'd0);
    check("cancel.d_rvalid", d_rvalid, 32'd0);
    tick();
    m_rvalid = 1'b0;
    run_txn("cancel.load", 1'b0, 1'b1, 1'b0, 32'h400, 1'b0, 32'h0, 4'h0,
            32'hCAFE_F00D);

    // ---- Cancel coincident with the response ----
    i_addr = 32'h900; i_req = 1'b1; m_ready = 1'b1;
    tick(); #1;
    check("cancel2.i_ready", i_ready, 32'd1);
    tick();
    i_req = 1'b0; m_ready = 1'b0;
    tick();
    m_rvalid = 1'b1; i_cancel = 1'b1; m_rdata = 32'h9999_0000;
    #1;
    check("cancel2.i_rvalid", i_rvalid, 32'd0);
    tick();
    m_rvalid = 1'b0; i_cancel = 1'b0;

    // ---- Back-pressure: five stalled ISSUE cycles ----
    d_addr = 32'h500; d_write = 1'b1; d_wdata = 32'hA5A5_0F0F; d_wstrb = 4'h6;
    d_req = 1'b1; m_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(); #1;
      check($sformatf("bp%0d.m_req", c),   m_req,   32'd1);
      check($sformatf("bp%0d.m_addr", c),  m_addr,  32'h500);
      check($sformatf("bp%0d.d_ready", c), d_ready, 32'd0);
      check($sformatf("bp%0d.i_ready", c), i_ready, 32'd0);
    end
    tick();
    m_ready = 1'b1;
    #1;
    check("bp5.m_req",   m_req,   32'd1);
    check("bp5.m_addr",  m_addr,  32'h500);
    check("bp5.d_ready", d_ready, 32'd1);
    tick();
    d_req = 1'b0; m_ready = 1'b0;
    #1;
    check("bp.wait_d_ready", d_ready, 32'd0);
    tick();
    m_rvalid = 1'b1; m_rdata = 32'h0000_00AC;
    #1;
    check("bp.d_rvalid", d_rvalid, 32'd1);
    tick();
    m_rvalid = 1'b0;

    // ---- Async reset in WAIT, late response ignored ----
    i_addr = 32'h600; i_req = 1'b1; m_ready = 1'b1;
    tick(); #1;
    check("rstw.i_ready", i_ready, 32'd1);
    tick();
    i_req = 1'b0; m_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rstw.m_req",  m_req,  32'd0);
    check("rstw.m_addr", m_addr, 32'd0);
    m_rvalid = 1'b1; m_rdata = 32'h7777_7777;
    #1;
    check("rstw.i_rvalid", i_rvalid, 32'd0);
    check("rstw.d_rvalid", d_rvalid, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rstw.late_i_rvalid", i_rvalid, 32'd0);
    check("rstw.late_d_rvalid", d_rvalid, 32'd0);
    tick();
    m_rvalid = 1'b0;

    // ---- Async reset in ISSUE drops m_req between edges ----
    i_addr = 32'h610; i_req = 1'b1; m_ready = 1'b0;
    tick(); #1;
    check("rsti.m_req_before", m_req, 32'd1);
    rst = 1'b1;
    #1;
    check("rsti.m_req_after", m_req,   32'd0);
    check("rsti.i_ready",     i_ready, 32'd0);
    i_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
